fb_write_arbiter: RTL
=====================

// Module: fb_write_arbiter
// PURPOSE
//   Shares the single text-framebuffer write port (fb_a/fb_d/fb_we) between two requesters.
//   Requester A is the vt100 terminal engine; requester B is the CPU bus bridge.
//   Arbitration is round-robin; one write per cycle. Outputs feed the HDMI text front end.
//   An optional clear engine fills the screen with a blank cell on command.
// PARAMETERS
//   AW          12        framebuffer address width (cells)
//   DW          16        cell width: {attr[7:0], char[7:0]}
//   FB_CELLS    2400      visible cells (80x30); clear-engine range 0..FB_CELLS-1
//   CLEAR_CELL  16'h0720  cell value written by the clear engine
// PORTS
//   clk        in   1   system clock (clk_main domain)
//   rst_n      in   1   asynchronous active-low reset
//   a_valid    in   1   requester A write request
//   a_ready    out  1   A accepted this cycle (a_valid & a_ready)
//   a_addr     in   AW  A cell address
//   a_data     in   DW  A cell value
//   b_valid    in   1   requester B write request
//   b_ready    out  1   B accepted this cycle
//   b_addr     in   AW  B cell address
//   b_data     in   DW  B cell value
//   clr_start  in   1   one-cycle pulse: start a screen clear (CLEAR_ENGINE_EN only)
//   clr_busy   out  1   clear in progress
//   fb_a       out  AW  framebuffer write address (registered)
//   fb_d       out  DW  framebuffer write data (registered)
//   fb_we      out  1   framebuffer write enable (registered, one cycle per write)
// BEHAVIOUR
//   - Reset: fb_a=0, fb_d=0, fb_we=0, clr_busy=0, last_grant=B (A wins first tie), state=ARB.
//   - Handshake: valid/ready. A requester holds valid, addr and data stable until ready.
//     ready is combinational from valid and state/last_grant. It never depends on its own
//     ready in a loop.
//   - ARB state:
//     only A valid -> a_ready=1; only B valid -> b_ready=1;
//     both valid -> grant the one not equal to last_grant.
//     last_grant updates only on an accepted transfer.
//   - Latency: transfer accepted in cycle N -> fb_we=1 with that addr/data in cycle N+1.
//     No buffering; fb_we=0 in any cycle with no accepted transfer the cycle before.
//   - Throughput: one write per cycle. Back-to-back bursts from both alternate A,B,A,B.
//   - Addresses pass through unmodified. Range checking is the requesters' job.
//   - CLEAR state (CLEAR_ENGINE_EN): entered on clr_start while in ARB.
//     The clear owns the port in the same cycle; a_ready=b_ready=0 from that cycle.
//     Writes CLEAR_CELL to addresses 0,1,...,FB_CELLS-1, one per cycle.
//     fb_we is high for FB_CELLS consecutive cycles starting at cycle N+1.
//     The counter is AW bits wide. The last write is at FB_CELLS-1; no wrap past it.
//     clr_busy is 1 from the cycle after clr_start through the cycle of the last fb_we.
//     The state returns to ARB after the last clear address is issued; requests are
//     accepted again in that cycle.
//     clr_start while busy is ignored (no restart, no queueing).
//     Requests pending during the clear stay pending; last_grant is unchanged by the clear.
//     A transfer accepted in the same cycle as clr_start is impossible: clr_start has
//     priority and ready is 0 that cycle.
//   - Reset asserted mid-clear or mid-transfer: immediate return to reset values; a
//     partial clear is not resumed.
// CONFIGURATION
//   FB_CLEAR_ENGINE_EN defined:
//     CLEAR state and counter present, behaving as above.
//   FB_CLEAR_ENGINE_EN undefined:
//     clr_start is ignored and clr_busy is tied to 0.
//     Pure two-way round-robin arbiter; no counter logic.
// STRUCTURE
//   - Shared package fb_pkg holds:
//     FB_AW=12, FB_DW=16, FB_CELLS=2400, FB_CLEAR_CELL=16'h0720;
//     requester-id encoding REQ_A=1'b0, REQ_B=1'b1;
//     state encoding ST_ARB, ST_CLEAR.
//   - One sub-module: rr_arb2. It is the two-input round-robin grant with a last_grant
//     register updated on accept. The output register and clear engine live in the top
//     of this block.
// TESTING
//   1. Reset, then A only: a_addr=0x010, a_data=0x0741 held valid 1 cycle.
//      -> a_ready=1; next cycle fb_we=1, fb_a=0x010, fb_d=0x0741; following cycle fb_we=0.
//   2. A and B both valid for 4 cycles from reset.
//      -> grants A,B,A,B; fb_we high 4 cycles in that order; each data value seen once.
//   3. B valid and held while A issues a 10-write burst.
//      -> B is granted by the 2nd cycle at latest; no requester is starved beyond 1 cycle.
//   4. FB_CLEAR_ENGINE_EN, pulse clr_start with A valid.
//      -> a_ready=0 for 2400 cycles; fb_we=1 for 2400 cycles at fb_a 0..2399, fb_d=0x0720.
//      -> clr_busy drops after the last write; A is then accepted.
//   5. clr_start again at clear address 1000.
//      -> ignored; total clear writes still 2400, ending at 2399.
//   6. rst_n low at clear address 500.
//      -> fb_we=0 and clr_busy=0 immediately.
//      -> after release, a new A write passes with 1-cycle latency.

Source files
------------

// File: rtl/fb_pkg.sv
// Shared framebuffer constants, requester ids and arbiter state encoding.
package fb_pkg;

  localparam int unsigned FB_AW         = 12;
  localparam int unsigned FB_DW         = 16;
  localparam int unsigned FB_CELLS      = 2400;
  localparam logic [15:0] FB_CLEAR_CELL = 16'h0720;

  typedef enum logic {
    REQ_A = 1'b0,
    REQ_B = 1'b1
  } fb_req_e;

  typedef enum logic {
    ST_ARB   = 1'b0,
    ST_CLEAR = 1'b1
  } fb_state_e;

endpackage

// File: rtl/fb_write_arbiter_rr_arb2.sv
// Two-input round-robin grant; last_grant advances only on an accepted transfer.
module rr_arb2
  import fb_pkg::*;
(
  input  logic clk_i,
  input  logic rst_ni,
  input  logic en_i,
  input  logic a_valid_i,
  input  logic b_valid_i,
  output logic a_gnt_o,
  output logic b_gnt_o
);

  fb_req_e last_q;

  always_comb begin
    a_gnt_o = en_i & a_valid_i & (~b_valid_i | (last_q == REQ_B));
    b_gnt_o = en_i & b_valid_i & (~a_valid_i | (last_q == REQ_A));
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      last_q <= REQ_B;
    end else if (a_gnt_o) begin
      last_q <= REQ_A;
    end else if (b_gnt_o) begin
      last_q <= REQ_B;
    end
  end

endmodule

// File: rtl/fb_write_arbiter.sv
// Text-framebuffer write-port arbiter (vt100 engine vs CPU bridge) with registered port.
// Optional screen-clear engine enabled by defining FB_CLEAR_ENGINE_EN.
module fb_write_arbiter
  import fb_pkg::*;
#(
  parameter int unsigned   AW         = FB_AW,
  parameter int unsigned   DW         = FB_DW,
  parameter int unsigned   FB_CELLS   = fb_pkg::FB_CELLS,
  parameter logic [DW-1:0] CLEAR_CELL = FB_CLEAR_CELL
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          a_valid,
  output logic          a_ready,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_data,
  input  logic          b_valid,
  output logic          b_ready,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_data,
  input  logic          clr_start,
  output logic          clr_busy,
  output logic [AW-1:0] fb_a,
  output logic [DW-1:0] fb_d,
  output logic          fb_we
);

  logic          arb_en;
  logic          a_gnt;
  logic          b_gnt;
  logic [AW-1:0] fb_a_q;
  logic [DW-1:0] fb_d_q;
  logic          fb_we_q;

  rr_arb2 u_rr_arb2 (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .en_i      (arb_en),
    .a_valid_i (a_valid),
    .b_valid_i (b_valid),
    .a_gnt_o   (a_gnt),
    .b_gnt_o   (b_gnt)
  );

  assign a_ready = a_gnt;
  assign b_ready = b_gnt;
  assign fb_a    = fb_a_q;
  assign fb_d    = fb_d_q;
  assign fb_we   = fb_we_q;

`ifdef FB_CLEAR_ENGINE_EN

  localparam logic [AW-1:0] LAST_CELL = AW'(FB_CELLS - 1);

  fb_state_e     state_q;
  logic [AW-1:0] cnt_q;
  logic          busy_q;
  logic          clr_go;

  // busy_q still covers the final clear write while the state is already ARB,
  // so a clr_start in that cycle is ignored as well.
  assign clr_go   = (state_q == ST_ARB) & clr_start & ~busy_q;
  assign arb_en   = (state_q == ST_ARB) & ~clr_go;
  assign clr_busy = busy_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_ARB;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      fb_a_q  <= '0;
      fb_d_q  <= '0;
      fb_we_q <= 1'b0;
    end else begin
      case (state_q)
        ST_ARB: begin
          if (clr_go) begin
            fb_a_q  <= '0;
            fb_d_q  <= CLEAR_CELL;
            fb_we_q <= 1'b1;
            cnt_q   <= AW'(1);
            busy_q  <= 1'b1;
            state_q <= (FB_CELLS > 1) ? ST_CLEAR : ST_ARB;
          end else begin
            busy_q <= 1'b0;
            if (a_gnt) begin
              fb_a_q  <= a_addr;
              fb_d_q  <= a_data;
              fb_we_q <= 1'b1;
            end else if (b_gnt) begin
              fb_a_q  <= b_addr;
              fb_d_q  <= b_data;
              fb_we_q <= 1'b1;
            end else begin
              fb_we_q <= 1'b0;
            end
          end
        end
        ST_CLEAR: begin
          fb_a_q  <= cnt_q;
          fb_d_q  <= CLEAR_CELL;
          fb_we_q <= 1'b1;
          busy_q  <= 1'b1;
          cnt_q   <= cnt_q + AW'(1);
          if (cnt_q == LAST_CELL) begin
            state_q <= ST_ARB;
          end
        end
        default: begin
          state_q <= ST_ARB;
          fb_we_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

`else

  logic unused_clr;

  assign arb_en     = 1'b1;
  assign clr_busy   = 1'b0;
  assign unused_clr = clr_start ^ (^CLEAR_CELL) ^ (FB_CELLS != 0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fb_a_q  <= '0;
      fb_d_q  <= '0;
      fb_we_q <= 1'b0;
    end else if (a_gnt) begin
      fb_a_q  <= a_addr;
      fb_d_q  <= a_data;
      fb_we_q <= 1'b1;
    end else if (b_gnt) begin
      fb_a_q  <= b_addr;
      fb_d_q  <= b_data;
      fb_we_q <= 1'b1;
    end else begin
      fb_we_q <= 1'b0;
    end
  end

`endif

endmodule
